// File: rtl/ff_bank_write_arbiter_pkg.sv
// ff_bank_write_arbiter_pkg: shared state type and decode helpers for the FF bank write arbiter.
package ff_bank_write_arbiter_pkg;

   typedef enum logic {IDLE, CFG} state_e;

   localparam int MAX_REGS = 32;

   function automatic int aw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [MAX_REGS-1:0] onehot(input int i);
      return MAX_REGS'(1) << i;
   endfunction

endpackage

// File: rtl/ff_bank_write_arbiter_rr_arbiter.sv
// ff_bank_write_arbiter_rr_arbiter: combinational round-robin pick starting at ptr.
module ff_bank_write_arbiter_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scanning from the far end lets the candidate closest to ptr overwrite the others.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            idx = IW'((int'(ptr) + k) % N);
            any = 1'b1;
         end
      end
      gnt = any ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/ff_bank_write_arbiter.sv
// ff_bank_write_arbiter: round-robin write arbitration and config broadcast into an enable-gated FF bank.
module ff_bank_write_arbiter
   import ff_bank_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int NUM_REGS = 4,
   parameter int W        = 4
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_REQ-1:0]                    io_req_valid,
   input  logic [NUM_REQ*aw_of(NUM_REGS)-1:0]    io_req_addr,
   input  logic [NUM_REQ*W-1:0]                  io_req_data,
   output logic [NUM_REQ-1:0]                    io_req_ready,
   input  logic                                  io_cfg_start,
   input  logic [W-1:0]                          io_cfg_data,
   output logic [NUM_REGS-1:0]                   io_ff_enable,
   output logic [W-1:0]                          io_ff_data,
   output logic                                  io_busy
);

   localparam int AW = aw_of(NUM_REGS);
   localparam int RW = aw_of(NUM_REQ);

   state_e              state_q, state_d;
   logic [RW-1:0]       rr_q, rr_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [W-1:0]        cfg_data_q, cfg_data_d;
   logic [NUM_REGS-1:0] en_q, en_d;
   logic [W-1:0]        data_q, data_d;
   logic                busy_q, busy_d;

   logic [NUM_REQ-1:0]  gnt;
   logic [RW-1:0]       win;
   logic                any;
   logic                grant;
   logic [AW-1:0]       win_addr;
   logic [W-1:0]        win_data;

   ff_bank_write_arbiter_rr_arbiter #(.N(NUM_REQ), .IW(RW)) u_rr (
      .req (io_req_valid),
      .ptr (rr_q),
      .gnt (gnt),
      .idx (win),
      .any (any)
   );

   // A start pulse in IDLE pre-empts every request that cycle.
   assign grant        = reset && (state_q == IDLE) && !io_cfg_start && any;
   assign io_req_ready = grant ? gnt : '0;
   assign win_addr     = io_req_addr[int'(win)*AW +: AW];
   assign win_data     = io_req_data[int'(win)*W +: W];

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      idx_d      = idx_q;
      cfg_data_d = cfg_data_q;
      en_d       = '0;
      data_d     = data_q;
      if (state_q == IDLE) begin
         if (io_cfg_start) begin
            state_d    = CFG;
            cfg_data_d = io_cfg_data;
            idx_d      = '0;
         end else if (any) begin
            en_d   = NUM_REGS'(onehot(int'(win_addr)));
            data_d = win_data;
            rr_d   = RW'((int'(win) + 1) % NUM_REQ);
         end
      end else begin
         en_d    = NUM_REGS'(onehot(int'(idx_q)));
         data_d  = cfg_data_q;
         idx_d   = idx_q + 1'b1;
         state_d = (idx_q == AW'(NUM_REGS - 1)) ? IDLE : CFG;
      end
      busy_d = (state_d == CFG);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         idx_q      <= '0;
         cfg_data_q <= '0;
         en_q       <= '0;
         data_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         idx_q      <= idx_d;
         cfg_data_q <= cfg_data_d;
         en_q       <= en_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
      end
   end

   assign io_ff_enable = en_q;
   assign io_ff_data   = data_q;
   assign io_busy      = busy_q;

endmodule

// File: tb/tb_ff_bank_write_arbiter.sv
// tb_ff_bank_write_arbiter: vector table plus hand sequences, next-cycle outputs checked through a queue.
module tb_ff_bank_write_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  io_req_valid;
   logic [7:0]  io_req_addr;
   logic [15:0] io_req_data;
   logic [3:0]  io_req_ready;
   logic        io_cfg_start;
   logic [3:0]  io_cfg_data;
   logic [3:0]  io_ff_enable;
   logic [3:0]  io_ff_data;
   logic        io_busy;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] en;
      logic [3:0] dat;
      logic       busy;
   } exp_t;

   typedef struct {
      logic        start;
      logic [3:0]  cfg;
      logic [3:0]  valid;
      logic [7:0]  addr;
      logic [15:0] data;
      logic [3:0]  rdy;
      logic [3:0]  en;
      logic [3:0]  dat;
      logic        busy;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];

   ff_bank_write_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .io_req_valid (io_req_valid),
      .io_req_addr  (io_req_addr),
      .io_req_data  (io_req_data),
      .io_req_ready (io_req_ready),
      .io_cfg_start (io_cfg_start),
      .io_cfg_data  (io_cfg_data),
      .io_ff_enable (io_ff_enable),
      .io_ff_data   (io_ff_data),
      .io_busy      (io_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic [3:0] cd, input logic [3:0] v,
                       input logic [7:0] a, input logic [15:0] d, input logic [3:0] rdy,
                       input logic [3:0] en, input logic [3:0] dat, input logic b);
      exp_t e;
      io_cfg_start = s;
      io_cfg_data  = cd;
      io_req_valid = v;
      io_req_addr  = a;
      io_req_data  = d;
      #1;
      chk("ready", io_req_ready, rdy);
      sb.push_back('{en, dat, b});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard @%0t: got empty queue expected entry", $time);
      end else begin
         e = sb.pop_front();
         chk("ff_enable", io_ff_enable, e.en);
         chk("ff_data", io_ff_data, e.dat);
         chk("busy", {3'b0, io_busy}, {3'b0, e.busy});
      end
      @(negedge clk);
   endtask

   initial begin
      reset        = 1'b0;
      io_cfg_start = 1'b0;
      io_cfg_data  = '0;
      io_req_valid = '0;
      io_req_addr  = '0;
      io_req_data  = '0;
      @(negedge clk);
      // reset held with every requester asking
      for (int i = 0; i < 2; i++)
         step(0, 4'h0, 4'b1111, 8'hE4, 16'h4321, 4'b0000, 4'b0000, 4'h0, 0);
      reset = 1'b1;

      tbl.push_back('{0, 4'h0, 4'b0100, 8'h30, 16'h0A00, 4'b0100, 4'b1000, 4'hA, 0});
      tbl.push_back('{0, 4'h0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'hA, 0});
      tbl.push_back('{0, 4'h0, 4'b1000, 8'h40, 16'h7000, 4'b1000, 4'b0010, 4'h7, 0});
      tbl.push_back('{0, 4'h0, 4'b1111, 8'hE4, 16'h4321, 4'b0001, 4'b0001, 4'h1, 0});
      tbl.push_back('{0, 4'h0, 4'b1111, 8'hE4, 16'h4321, 4'b0010, 4'b0010, 4'h2, 0});
      tbl.push_back('{0, 4'h0, 4'b1111, 8'hE4, 16'h4321, 4'b0100, 4'b0100, 4'h3, 0});
      tbl.push_back('{0, 4'h0, 4'b1111, 8'hE4, 16'h4321, 4'b1000, 4'b1000, 4'h4, 0});
      tbl.push_back('{0, 4'h0, 4'b1111, 8'hE4, 16'h4321, 4'b0001, 4'b0001, 4'h1, 0});
      tbl.push_back('{0, 4'h0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'h1, 0});
      tbl.push_back('{0, 4'h0, 4'b1001, 8'h81, 16'h9006, 4'b1000, 4'b0100, 4'h9, 0});
      tbl.push_back('{0, 4'h0, 4'b0001, 8'h81, 16'h9006, 4'b0001, 4'b0010, 4'h6, 0});
      foreach (tbl[i])
         step(tbl[i].start, tbl[i].cfg, tbl[i].valid, tbl[i].addr, tbl[i].data,
              tbl[i].rdy, tbl[i].en, tbl[i].dat, tbl[i].busy);

      // broadcast of 5 with req 1 waiting; a second start mid-broadcast must be ignored
      step(1, 4'h5, 4'b0010, 8'h08, 16'h00C0, 4'b0000, 4'b0000, 4'h6, 1);
      step(0, 4'h0, 4'b0010, 8'h08, 16'h00C0, 4'b0000, 4'b0001, 4'h5, 1);
      step(0, 4'h0, 4'b0010, 8'h08, 16'h00C0, 4'b0000, 4'b0010, 4'h5, 1);
      step(1, 4'hF, 4'b0010, 8'h08, 16'h00C0, 4'b0000, 4'b0100, 4'h5, 1);
      step(0, 4'h0, 4'b0010, 8'h08, 16'h00C0, 4'b0000, 4'b1000, 4'h5, 0);
      step(0, 4'h0, 4'b0010, 8'h08, 16'h00C0, 4'b0010, 4'b0100, 4'hC, 0);
      step(0, 4'h0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'hC, 0);

      // reset after two broadcast enables
      step(1, 4'h3, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'hC, 1);
      step(0, 4'h0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0001, 4'h3, 1);
      step(0, 4'h0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0010, 4'h3, 1);
      reset = 1'b0;
      step(0, 4'h0, 4'b1111, 8'hE4, 16'h4321, 4'b0000, 4'b0000, 4'h0, 0);
      reset = 1'b1;
      step(0, 4'h0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'h0, 0);
      step(0, 4'h0, 4'b0000, 8'h00, 16'h0000, 4'b0000, 4'b0000, 4'h0, 0);
      step(0, 4'h0, 4'b1111, 8'hE4, 16'h4321, 4'b0001, 4'b0001, 4'h1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
